// File: rtl/m3_pkg.sv
// Shared constants, state encoding and mod-12 index helpers for the M3 step engine.
package m3_pkg;

  localparam int unsigned STEPS_PER_ROUND = 12;
  localparam int unsigned LEN_W           = 22;
  localparam int unsigned ROUND_W         = 26;

  localparam logic [LEN_W-1:0] PERIOD_MIN = 22'd40;
`ifdef SIMULATION
  localparam logic [LEN_W-1:0] PERIOD_MAX = 22'd300;
`else
  localparam logic [LEN_W-1:0] PERIOD_MAX = 22'd4000000;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_e;

  function automatic logic [3:0] idx_next(input logic [3:0] idx);
    return (idx == 4'd11) ? 4'd0 : idx + 4'd1;
  endfunction

  function automatic logic [3:0] idx_prev(input logic [3:0] idx);
    return (idx == 4'd0) ? 4'd11 : idx - 4'd1;
  endfunction

endpackage

// File: rtl/m3_interval_cnt.sv
// Saturating interval counter: reloads 1 on a strobe, flags when it sits at PERIOD_MAX.
module m3_interval_cnt #(
  parameter int unsigned      LEN_W      = m3_pkg::LEN_W,
  parameter logic [LEN_W-1:0] PERIOD_MAX = m3_pkg::PERIOD_MAX
) (
  input  logic             clkI,
  input  logic             nRstI,
  input  logic             clrI,
  input  logic             loadI,
  output logic [LEN_W-1:0] cntO,
  output logic             satO
);

  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clrI || loadI) begin
      cnt_d = LEN_W'(1);
    end else if (cnt_q != PERIOD_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      cnt_q <= LEN_W'(1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cntO = cnt_q;
  assign satO = (cnt_q == PERIOD_MAX);

endmodule

// File: rtl/m3_step_measure.sv
// Step-interval measurement for the M3 12-step sequencer: validates the index
// sequence, tracks direction and lock, and reports step/round length, stall and over-speed.
module m3_step_measure #(
  parameter int unsigned      LEN_W      = m3_pkg::LEN_W,
  parameter logic [LEN_W-1:0] PERIOD_MAX = m3_pkg::PERIOD_MAX,
  parameter logic [LEN_W-1:0] PERIOD_MIN = m3_pkg::PERIOD_MIN,
  parameter int unsigned      LOCK_CNT   = 3
) (
  input  logic                       clkI,
  input  logic                       nRstI,
  input  logic                       enI,
  input  logic                       stepStrobeI,
  input  logic [3:0]                 stepIdxI,
  output logic [LEN_W-1:0]           stepLenO,
  output logic                       stepLenValidO,
  output logic [m3_pkg::ROUND_W-1:0] roundLenO,
  output logic                       roundValidO,
  output logic                       dirO,
  output logic                       lockedO,
  output logic                       stallO,
  output logic                       seqErrO,
  output logic                       tooFastO
);

  import m3_pkg::state_e;
  import m3_pkg::IDLE;
  import m3_pkg::SYNC;
  import m3_pkg::TRACK;
  import m3_pkg::LOCKED;
  import m3_pkg::ROUND_W;
  import m3_pkg::STEPS_PER_ROUND;
  import m3_pkg::idx_next;
  import m3_pkg::idx_prev;

  localparam int unsigned GOOD_W   = $clog2(LOCK_CNT + 1);
  localparam logic [3:0]  IDX_LIM  = 4'(STEPS_PER_ROUND);
  localparam logic [3:0]  LAST_STEP = 4'(STEPS_PER_ROUND - 1);

  state_e              state_q, state_d;
  logic [3:0]          ref_q, ref_d;
  logic                dir_q, dir_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [ROUND_W-1:0]  acc_q, acc_d;
  logic [3:0]          rstep_q, rstep_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                len_vld_q, len_vld_d;
  logic [ROUND_W-1:0]  round_q, round_d;
  logic                round_vld_q, round_vld_d;
  logic                locked_q, locked_d;
  logic                stall_q, stall_d;
  logic                seq_err_q, seq_err_d;
  logic                fast_q, fast_d;

  logic [LEN_W-1:0]    interval;
  logic                sat;
  logic                fwd, rev, in_order, too_fast;
  logic [GOOD_W-1:0]   good_inc;
  logic [ROUND_W-1:0]  acc_sum;

  m3_interval_cnt #(
    .LEN_W      (LEN_W),
    .PERIOD_MAX (PERIOD_MAX)
  ) u_cnt (
    .clkI  (clkI),
    .nRstI (nRstI),
    .clrI  (~enI),
    .loadI (stepStrobeI),
    .cntO  (interval),
    .satO  (sat)
  );

  always_comb begin
    // An out-of-range reference (left behind by an illegal index) matches nothing.
    fwd      = (stepIdxI < IDX_LIM) && (ref_q < IDX_LIM) && (stepIdxI == idx_next(ref_q));
    rev      = (stepIdxI < IDX_LIM) && (ref_q < IDX_LIM) && (stepIdxI == idx_prev(ref_q));
    in_order = (state_q == SYNC) ? (fwd || rev) : (dir_q ? rev : fwd);
    too_fast = (interval < PERIOD_MIN);
    good_inc = good_q + 1'b1;
    acc_sum  = acc_q + ROUND_W'(interval);

    state_d     = state_q;
    ref_d       = ref_q;
    dir_d       = dir_q;
    good_d      = good_q;
    acc_d       = acc_q;
    rstep_d     = rstep_q;
    len_d       = len_q;
    round_d     = round_q;
    locked_d    = locked_q;
    stall_d     = stall_q;
    fast_d      = fast_q;
    len_vld_d   = 1'b0;
    round_vld_d = 1'b0;
    seq_err_d   = 1'b0;

    if (!enI) begin
      state_d  = IDLE;
      ref_d    = '0;
      dir_d    = 1'b0;
      good_d   = '0;
      acc_d    = '0;
      rstep_d  = '0;
      len_d    = '0;
      round_d  = '0;
      locked_d = 1'b0;
      stall_d  = 1'b0;
      fast_d   = 1'b0;
    end else if (stepStrobeI) begin
      stall_d = 1'b0;
      ref_d   = stepIdxI;
      if (state_q == IDLE) begin
        state_d = SYNC;
      end else begin
        len_d     = interval;
        len_vld_d = 1'b1;
        if (too_fast) begin
          fast_d = 1'b1;
        end
        if (!in_order || too_fast) begin
          seq_err_d = 1'b1;
          locked_d  = 1'b0;
          good_d    = '0;
          acc_d     = '0;
          rstep_d   = '0;
          state_d   = SYNC;
        end else if (state_q == LOCKED) begin
          if (rstep_q == LAST_STEP) begin
            round_d     = acc_sum;
            round_vld_d = 1'b1;
            acc_d       = '0;
            rstep_d     = '0;
          end else begin
            acc_d   = acc_sum;
            rstep_d = rstep_q + 4'd1;
          end
        end else begin
          // SYNC always enters with good_q == 0, so it shares the TRACK count-up path.
          if (state_q == SYNC) begin
            dir_d = rev;
          end
          good_d = good_inc;
          if (good_inc == GOOD_W'(LOCK_CNT)) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end else begin
            state_d = TRACK;
          end
        end
      end
    end else if (sat) begin
      stall_d  = 1'b1;
      locked_d = 1'b0;
      state_d  = IDLE;
      good_d   = '0;
      acc_d    = '0;
      rstep_d  = '0;
    end
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state_q     <= IDLE;
      ref_q       <= '0;
      dir_q       <= 1'b0;
      good_q      <= '0;
      acc_q       <= '0;
      rstep_q     <= '0;
      len_q       <= '0;
      len_vld_q   <= 1'b0;
      round_q     <= '0;
      round_vld_q <= 1'b0;
      locked_q    <= 1'b0;
      stall_q     <= 1'b0;
      seq_err_q   <= 1'b0;
      fast_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      dir_q       <= dir_d;
      good_q      <= good_d;
      acc_q       <= acc_d;
      rstep_q     <= rstep_d;
      len_q       <= len_d;
      len_vld_q   <= len_vld_d;
      round_q     <= round_d;
      round_vld_q <= round_vld_d;
      locked_q    <= locked_d;
      stall_q     <= stall_d;
      seq_err_q   <= seq_err_d;
      fast_q      <= fast_d;
    end
  end

  assign stepLenO      = len_q;
  assign stepLenValidO = len_vld_q;
  assign roundLenO     = round_q;
  assign roundValidO   = round_vld_q;
  assign dirO          = dir_q;
  assign lockedO       = locked_q;
  assign stallO        = stall_q;
  assign seqErrO       = seq_err_q;
  assign tooFastO      = fast_q;

endmodule

// File: tb/tb_m3_step_measure.sv
// Directed bench for m3_step_measure: an event-level model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_m3_step_measure;

  localparam int PMAX = 300;
  localparam int PMIN = 40;
  localparam int LOCK = 3;

  logic        clkI = 1'b0;
  logic        nRstI;
  logic        enI;
  logic        stepStrobeI;
  logic [3:0]  stepIdxI;
  logic [21:0] stepLenO;
  logic        stepLenValidO;
  logic [25:0] roundLenO;
  logic        roundValidO;
  logic        dirO;
  logic        lockedO;
  logic        stallO;
  logic        seqErrO;
  logic        tooFastO;

  int n_chk  = 0;
  int n_pass = 0;

  m3_step_measure #(
    .LEN_W      (22),
    .PERIOD_MAX (22'd300),
    .PERIOD_MIN (22'd40),
    .LOCK_CNT   (3)
  ) dut (
    .clkI          (clkI),
    .nRstI         (nRstI),
    .enI           (enI),
    .stepStrobeI   (stepStrobeI),
    .stepIdxI      (stepIdxI),
    .stepLenO      (stepLenO),
    .stepLenValidO (stepLenValidO),
    .roundLenO     (roundLenO),
    .roundValidO   (roundValidO),
    .dirO          (dirO),
    .lockedO       (lockedO),
    .stallO        (stallO),
    .seqErrO       (seqErrO),
    .tooFastO      (tooFastO)
  );

  always #5 clkI = ~clkI;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: intervals are edge-count differences, lock is a run of in-order steps.
  int  now = 0, last_t = 0;
  bit  have_ref = 0;
  int  ref_idx = 0, run = 0, rsum = 0, rcount = 0;
  int  m_len = 0, m_round = 0;
  bit  m_lenv = 0, m_rv = 0, m_dir = 0, m_stall = 0, m_err = 0, m_fast = 0;

  always @(posedge clkI) begin
    int iv, idx;
    bit fwd, rev, ok, fast;
    now++;
    m_lenv = 0; m_rv = 0; m_err = 0;
    if (!nRstI || !enI) begin
      last_t = now; have_ref = 0; run = 0; rsum = 0; rcount = 0; ref_idx = 0;
      m_len = 0; m_round = 0; m_dir = 0; m_stall = 0; m_fast = 0;
    end else if (stepStrobeI) begin
      iv = (now - last_t > PMAX) ? PMAX : now - last_t;
      idx = int'(stepIdxI);
      last_t = now;
      m_stall = 0;
      if (!have_ref) begin
        have_ref = 1; run = 0;
      end else begin
        m_len = iv; m_lenv = 1;
        fast = (iv < PMIN);
        if (fast) m_fast = 1;
        fwd = (idx < 12) && (ref_idx < 12) && (idx == (ref_idx + 1) % 12);
        rev = (idx < 12) && (ref_idx < 12) && (idx == (ref_idx + 11) % 12);
        ok  = !fast && ((run == 0) ? (fwd || rev) : (m_dir ? rev : fwd));
        if (ok) begin
          if (run == 0) m_dir = rev;
          if (run >= LOCK) begin
            rsum += iv; rcount++;
            if (rcount == 12) begin
              m_round = rsum; m_rv = 1; rsum = 0; rcount = 0;
            end
          end
          run++;
        end else begin
          m_err = 1; run = 0; rsum = 0; rcount = 0;
        end
      end
      ref_idx = idx;
    end else if (now - last_t >= PMAX) begin
      m_stall = 1; have_ref = 0; run = 0; rsum = 0; rcount = 0;
    end
    #1;
    n_chk++;
    if (stepLenO == 22'(m_len) && stepLenValidO == m_lenv && roundLenO == 26'(m_round) &&
        roundValidO == m_rv && dirO == m_dir && lockedO == (have_ref && run >= LOCK) &&
        stallO == m_stall && seqErrO == m_err && tooFastO == m_fast)
      n_pass++;
    else
      $display("FAIL outputs edge %0d: got len=%0d lv=%0b round=%0d rv=%0b dir=%0b lk=%0b st=%0b err=%0b tf=%0b; expected len=%0d lv=%0b round=%0d rv=%0b dir=%0b lk=%0b st=%0b err=%0b tf=%0b",
               now, stepLenO, stepLenValidO, roundLenO, roundValidO, dirO, lockedO, stallO, seqErrO, tooFastO,
               m_len, m_lenv, m_round, m_rv, m_dir, (have_ref && run >= LOCK), m_stall, m_err, m_fast);
  end

  // Called at a falling edge; the strobe is sampled 'gap' rising edges later.
  task automatic step(input int gap, input int idx);
    repeat (gap - 1) @(negedge clkI);
    stepStrobeI = 1'b1;
    stepIdxI    = 4'(idx);
    @(negedge clkI);
    stepStrobeI = 1'b0;
  endtask

  initial begin
    nRstI = 1'b0; enI = 1'b0; stepStrobeI = 1'b0; stepIdxI = '0;
    repeat (3) @(negedge clkI);
    chk("reset_len", stepLenO, 0);
    chk("reset_lock", lockedO, 0);
    chk("reset_round", roundLenO, 0);
    nRstI = 1'b1; enI = 1'b1;

    for (int k = 0; k < 16; k++) begin
      step(100, k % 12);
      if (k == 0) chk("fwd_first_no_valid", stepLenValidO, 0);
      if (k == 1) chk("fwd_len", stepLenO, 100);
      if (k == 2) chk("fwd_not_locked_yet", lockedO, 0);
      if (k == 3) begin chk("fwd_locked", lockedO, 1); chk("fwd_dir", dirO, 0); end
      if (k == 14) chk("fwd_no_round_yet", roundValidO, 0);
      if (k == 15) begin chk("fwd_round_valid", roundValidO, 1); chk("fwd_round_len", roundLenO, 1200); end
    end

    step(100, 5);
    chk("jump_err", seqErrO, 1);
    chk("jump_unlock", lockedO, 0);
    chk("jump_len", stepLenO, 100);
    step(100, 6);
    step(100, 7);
    chk("relock_pending", lockedO, 0);
    step(100, 8);
    chk("relock", lockedO, 1);
    for (int k = 0; k < 12; k++) begin
      step(80, (9 + k) % 12);
      if (k == 11) begin chk("relock_round_valid", roundValidO, 1); chk("relock_round_len", roundLenO, 960); end
    end

    step(20, 9);
    chk("fast_flag", tooFastO, 1);
    chk("fast_err", seqErrO, 1);
    chk("fast_len", stepLenO, 20);
    chk("fast_len_valid", stepLenValidO, 1);
    step(100, 10);
    step(100, 11);
    step(100, 0);
    chk("fast_relock", lockedO, 1);
    chk("fast_sticky", tooFastO, 1);

    repeat (299) @(negedge clkI);
    chk("stall_not_yet", stallO, 0);
    @(negedge clkI);
    chk("stall_at_max", stallO, 1);
    chk("stall_unlock", lockedO, 0);
    repeat (5) @(negedge clkI);
    step(10, 3);
    chk("stall_cleared", stallO, 0);
    chk("stall_no_len_valid", stepLenValidO, 0);

    chk("fast_survives_stall", tooFastO, 1);
    enI = 1'b0;
    #1 chk("en_low_not_immediate", tooFastO, 1);
    @(posedge clkI); #1;
    chk("en_low_fast_clear", tooFastO, 0);
    @(negedge clkI);
    enI = 1'b1;

    for (int k = 0; k < 16; k++) begin
      int v;
      v = 5 - k;
      if (v < 0) v += 12;
      step(50, v);
      if (k == 1) chk("rev_dir", dirO, 1);
      if (k == 3) chk("rev_locked", lockedO, 1);
      if (k == 15) begin chk("rev_round_valid", roundValidO, 1); chk("rev_round_len", roundLenO, 600); end
    end

    step(50, 12);
    chk("illegal_idx_err", seqErrO, 1);
    step(50, 3);
    chk("after_illegal_err", seqErrO, 1);
    step(50, 2);
    chk("resync_ok", seqErrO, 0);
    chk("resync_dir", dirO, 1);
    step(50, 3);
    chk("reversal_err", seqErrO, 1);

    step(300, 4);
    chk("sat_strobe_len", stepLenO, 300);
    chk("sat_strobe_no_stall", stallO, 0);
    chk("sat_strobe_valid", stepLenValidO, 1);
    step(100, 5);
    step(100, 6);
    chk("pre_reset_locked", lockedO, 1);

    #2 nRstI = 1'b0;
    #1;
    chk("async_reset_lock", lockedO, 0);
    chk("async_reset_len", stepLenO, 0);
    chk("async_reset_round", roundLenO, 0);
    @(negedge clkI);
    nRstI = 1'b1;
    step(100, 7);
    chk("post_reset_no_valid", stepLenValidO, 0);
    step(100, 8);
    chk("post_reset_len", stepLenO, 100);
    repeat (5) @(negedge clkI);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
